// File: rtl/sr_flag_arbiter_if.sv
// Request/grant and SR-drive bundle shared between requesters and the flag arbiter.
interface sr_flag_arbiter_if #(
    parameter int N = 4
);
    logic [N-1:0] req;
    logic [N-1:0] op;
    logic [N-1:0] gnt;
    logic         s;
    logic         r;
    logic         q;
    logic         busy;

    modport master (output req, op, input gnt, s, r, q, busy);
    modport slave  (input req, op, output gnt, s, r, q, busy);
endinterface

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter sharing one SR-latch status flag; drives fixed-width s/r
// pulses separated by a guard gap so the latch never sees s and r together.
module sr_flag_arbiter #(
    parameter int N       = 4,
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 1
) (
    input  logic               clk,
    input  logic               rst,
    sr_flag_arbiter_if.slave   bus
);
    localparam int MAXC = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int PTRW = $clog2(N);

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_PULSE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_IDLE  = 2'd3;

    localparam logic [CW-1:0] CNT_PULSE = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] CNT_GAP   = CW'(GAP_W - 1);

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PTRW-1:0] ptr_q, ptr_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic            s_q, s_d;
    logic            r_q, r_d;
    logic            q_q, q_d;
    logic            busy_q, busy_d;

    logic [N-1:0]    masked_req;
    logic [N-1:0]    pick;
    logic [PTRW-1:0] win_idx;
    logic [PTRW-1:0] win_next;

    // Requests at or above ptr take priority; otherwise wrap to the lowest index.
    always_comb begin
        masked_req = '0;
        win_idx    = '0;
        for (int i = 0; i < N; i++) begin
            masked_req[i] = bus.req[i] && (PTRW'(i) >= ptr_q);
        end
        pick = (masked_req != '0) ? masked_req : bus.req;
        for (int i = N - 1; i >= 0; i--) begin
            if (pick[i]) begin
                win_idx = PTRW'(i);
            end
        end
        win_next = (win_idx == PTRW'(N - 1)) ? '0 : win_idx + PTRW'(1);
    end

    always_comb begin
        // NOTE: every _d starts from its flop value (gnt from 0), so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        s_d     = s_q;
        r_d     = r_q;
        q_d     = q_q;

        case (state_q)
            ST_INIT: begin
                if (cnt_q == '0) begin
                    r_d     = 1'b0;
                    cnt_d   = CNT_GAP;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    s_d     = 1'b0;
                    r_d     = 1'b0;
                    cnt_d   = CNT_GAP;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                if (bus.req != '0) begin
                    gnt_d[win_idx] = 1'b1;
                    ptr_d          = win_next;
                    // A request matching the current flag is acknowledged without a pulse.
                    if (bus.op[win_idx] != q_q) begin
                        s_d     = bus.op[win_idx];
                        r_d     = ~bus.op[win_idx];
                        q_d     = bus.op[win_idx];
                        cnt_d   = CNT_PULSE;
                        state_d = ST_PULSE;
                    end
                end
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= CNT_PULSE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            s_q     <= 1'b0;
            r_q     <= 1'b1;
            q_q     <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            s_q     <= s_d;
            r_q     <= r_d;
            q_q     <= q_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.s    = s_q;
    assign bus.r    = r_q;
    assign bus.q    = q_q;
    assign bus.busy = busy_q;
endmodule

// File: doc/sr_flag_arbiter.md
# sr_flag_arbiter

Shares one SR-latch-controlled status flag between N requesters. Each requester asks to set or clear the flag. The block grants them round-robin, one at a time, and drives the latch's `s`/`r` inputs with fixed-width pulses separated by a guard gap. `s` and `r` are never high together, so the forbidden SR state is unreachable. After reset, a reset pulse forces the latch into a known state, and `q` tracks the commanded flag value for the rest of the design.

## Interface
- `N`, 4: number of requesters (≥2).
- `PULSE_W`, 2: cycles that `s` or `r` is held high per operation (≥1).
- `GAP_W`, 1: cycles with `s`=`r`=0 after each pulse, before the next grant is possible (≥1).

- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in N: request vector. Requester i holds `req[i]` high until it sees `gnt[i]`.
- `op` in N: `op[i]`=1 requests set, 0 requests clear. Sampled only in the cycle requester i is granted.
- `gnt` out N: one-hot, single-cycle acknowledge.
- `s` out 1: latch set drive (registered).
- `r` out 1: latch reset drive (registered).
- `q` out 1: commanded flag state (registered).
- `busy` out 1: high whenever state ≠ IDLE (registered).

## Operation
- Reset (edge with `rst`=1), regardless of current state:
  - state=INIT, cnt=PULSE_W−1, ptr=0.
  - Outputs: `s`=0, `r`=1, `q`=0, `gnt`=0, `busy`=1.
- States: INIT, PULSE, GAP, IDLE.
- INIT:
  - Hold `r`=1.
  - When cnt==0: `r`←0, cnt←GAP_W−1, go to GAP. Otherwise cnt←cnt−1.
- IDLE, with `req` nonzero:
  - Winner i is the first asserted bit scanning ptr, ptr+1, …, wrapping at N.
  - `gnt`←onehot(i), ptr←(i+1) mod N.
- IDLE, winner's `op[i]` ≠ `q` (effective request):
  - `s`←op[i], `r`←~op[i], `q`←op[i].
  - cnt←PULSE_W−1, go to PULSE.
- IDLE, winner's `op[i]` == `q` (redundant request):
  - Grant only. No pulse, stay in IDLE, `busy` stays 0.
- PULSE:
  - When cnt==0: `s`←0, `r`←0, cnt←GAP_W−1, go to GAP. Otherwise cnt←cnt−1.
- GAP:
  - When cnt==0: go to IDLE. Otherwise cnt←cnt−1.
- No grants are issued outside IDLE. Requests wait, holding `req` high.
- `gnt` is forced to 0 in every cycle after the granting cycle.
- Invariants:
  - `s`&`r` is never 1.
  - `gnt` is at most one-hot.
  - `q` changes only in the edge that starts a pulse, or on reset.
- Counter width is clog2(max(PULSE_W,GAP_W)); it never wraps.
- A requester must drop `req[i]` in the cycle `gnt[i]` is high. If `req[i]` is still high at the next IDLE evaluation, it counts as a new request.

## Timing
- Latency: a request seen at edge E in IDLE produces `gnt` and `s`/`r` high in the cycle after E.
- Pulse width: `s` or `r` is high for exactly PULSE_W cycles, followed by exactly GAP_W cycles of both low.
- Effective-grant period: PULSE_W+GAP_W+1 cycles. Default is 4 cycles per set/clear.
- Redundant grants: can issue back-to-back, one per cycle.
- Reset release:
  - `r` stays high for PULSE_W cycles after the first edge with `rst`=0 (INIT counts down).
  - Then GAP_W cycles of both low.
  - `busy` falls after PULSE_W+GAP_W cycles.
  - The first grant is possible at the following edge.
- Reset mid-PULSE or mid-GAP: in the next cycle `s`=0 and `r`=1, and `q`=0. The pending operation is dropped. An aborted requester that was already granted is not re-granted.
- Simultaneous requests: served strictly in round-robin order starting at ptr. There is no starvation; worst-case wait is N·(PULSE_W+GAP_W+1) cycles.

## Test plan
- **Reset release.** Hold `rst` 3 cycles, then release.
  - During reset: `r`=1, `s`=0, `busy`=1, `q`=0.
  - After release: `r`=1 for 2 more cycles, both low 1 cycle, then `busy`=0.
- **Single set.** `req`=0100, `op[2]`=1 in IDLE.
  - Next cycle: `gnt`=0100 for 1 cycle, `s`=1 for 2 cycles, `q`=1, `busy`=1.
  - `busy` stays high 3 cycles.
- **All request together.** `req`=1111, `op`=1010, ptr=0, `q`=0, each requester dropping `req` on its grant.
  - Grant order: 0 redundant (gnt only, cycle 1), 1 set, 2 clear, 3 set.
  - Effective grants spaced 4 cycles apart. `s`/`r` alternate, `q` ends at 1.
- **Redundant stream.** `q`=1; requesters 0 and 1 each request `op`=1.
  - `gnt` 0001, then 0010 on consecutive cycles.
  - `s`/`r` stay 0, `busy` stays 0.
- **Reset mid-pulse.** Assert `rst` in the second cycle of an `s` pulse.
  - Next cycle: `s`=0, `r`=1, `q`=0, `gnt`=0. Then the normal INIT sequence.
- **Invariant checkers, all scenarios.**
  - `s`&`r` never 1.
  - `$countones(gnt)` ≤ 1.
  - `s`/`r` high-time is always exactly PULSE_W cycles except when cut by reset.
